// File: rtl/writeback_queue.sv
`timescale 1ns/1ps
// Dual-lane writeback queue: buffers result pairs and drives the
// register bank's enable-then-data write protocol with a pending scoreboard.
module writeback_queue #(
  parameter int DEPTH = 4
) (
  input  logic       i_CLK,
  input  logic       i_RST_N,
  input  logic       i_Valid1,
  input  logic [2:0] i_Dest1,
  input  logic [7:0] i_Result1,
  input  logic       i_Valid2,
  input  logic [2:0] i_Dest2,
  input  logic [7:0] i_Result2,
  input  logic       i_Hold,
  output logic       o_Ready,
  output logic       o_WriteBack,
  output logic       o_WriteBack2,
  output logic [2:0] o_AddrRegDest,
  output logic [2:0] o_AddrRegDest2,
  output logic [7:0] o_WriteData,
  output logic [7:0] o_WriteData2,
  output logic [7:0] o_Pending,
  output logic       o_Overflow
);

  localparam int PW = $clog2(DEPTH);

  typedef struct packed {
    logic       v1;
    logic [2:0] d1;
    logic [7:0] r1;
    logic       v2;
    logic [2:0] d2;
    logic [7:0] r2;
  } pair_t;

  pair_t         mem [DEPTH];
  pair_t         inPair;
  pair_t         head;
  logic [PW-1:0] wrPtr;
  logic [PW-1:0] rdPtr;
  logic [PW:0]   count;
  logic          anyValid;
  logic          push;
  logic          pop;
  logic [7:0]    enR1;
  logic [7:0]    enR2;
  logic          dv1;
  logic          dv2;
  logic [2:0]    dd1;
  logic [2:0]    dd2;
  logic [7:0]    pend;

  assign anyValid = i_Valid1 | i_Valid2;
  assign o_Ready  = count < (PW+1)'(DEPTH);
  assign push     = anyValid & o_Ready;
  assign pop      = (count != '0) & ~i_Hold;
  assign head     = mem[rdPtr];

  // lane 2 is later in program order, so it wins a shared destination
  always_comb begin
    inPair    = '0;
    inPair.v1 = i_Valid1 &
                ~(i_Valid2 & (i_Dest1 == i_Dest2));
    inPair.d1 = i_Dest1;
    inPair.r1 = i_Result1;
    inPair.v2 = i_Valid2;
    inPair.d2 = i_Dest2;
    inPair.r2 = i_Result2;
  end

  always_ff @(posedge i_CLK) begin
    if (push) mem[wrPtr] <= inPair;
  end

  always_ff @(posedge i_CLK or negedge i_RST_N) begin
    if (!i_RST_N) begin
      count      <= '0;
      wrPtr      <= '0;
      rdPtr      <= '0;
      o_Overflow <= 1'b0;
    end else begin
      if (push) wrPtr <= wrPtr + 1'b1;
      if (pop)  rdPtr <= rdPtr + 1'b1;
      if (anyValid & ~o_Ready) o_Overflow <= 1'b1;
      unique case ({push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  always_ff @(posedge i_CLK or negedge i_RST_N) begin
    if (!i_RST_N) begin
      o_WriteBack    <= 1'b0;
      o_WriteBack2   <= 1'b0;
      o_AddrRegDest  <= '0;
      o_AddrRegDest2 <= '0;
      enR1           <= '0;
      enR2           <= '0;
    end else if (pop) begin
      o_WriteBack    <= head.v1;
      o_WriteBack2   <= head.v2;
      o_AddrRegDest  <= head.d1;
      o_AddrRegDest2 <= head.d2;
      enR1           <= head.r1;
      enR2           <= head.r2;
    end else begin
      o_WriteBack    <= 1'b0;
      o_WriteBack2   <= 1'b0;
    end
  end

  always_ff @(posedge i_CLK or negedge i_RST_N) begin
    if (!i_RST_N) begin
      o_WriteData  <= '0;
      o_WriteData2 <= '0;
      dv1          <= 1'b0;
      dv2          <= 1'b0;
      dd1          <= '0;
      dd2          <= '0;
    end else begin
      o_WriteData  <= enR1;
      o_WriteData2 <= enR2;
      dv1          <= o_WriteBack;
      dv2          <= o_WriteBack2;
      dd1          <= o_AddrRegDest;
      dd2          <= o_AddrRegDest2;
    end
  end

  // occupancy of slot i is its distance from the head vs. count
  always_comb begin
    logic [PW-1:0] offs;
    pend = '0;
    offs = '0;
    for (int i = 0; i < DEPTH; i++) begin
      offs = PW'(i) - rdPtr;
      if ({1'b0, offs} < count) begin
        if (mem[i].v1) pend[mem[i].d1] = 1'b1;
        if (mem[i].v2) pend[mem[i].d2] = 1'b1;
      end
    end
    if (o_WriteBack)  pend[o_AddrRegDest]  = 1'b1;
    if (o_WriteBack2) pend[o_AddrRegDest2] = 1'b1;
    if (dv1) pend[dd1] = 1'b1;
    if (dv2) pend[dd2] = 1'b1;
  end

  assign o_Pending = pend;

endmodule

// File: tb/tb_writeback_queue.sv
`timescale 1ns/1ps
// Bench for writeback_queue: vector table, corner sequences and
// randomized traffic against a queue-level reference model.
module tb_writeback_queue;

  localparam int DEPTH = 4;

  logic       clk = 1'b0;
  logic       rstN;
  logic       v1, v2, hold;
  logic [2:0] d1, d2;
  logic [7:0] r1, r2;
  logic       rdy, wb1, wb2, ovf;
  logic [2:0] a1, a2;
  logic [7:0] wd1, wd2, pnd;

  always #5 clk = ~clk;

  writeback_queue #(.DEPTH(DEPTH)) dut (
    .i_CLK(clk), .i_RST_N(rstN),
    .i_Valid1(v1), .i_Dest1(d1), .i_Result1(r1),
    .i_Valid2(v2), .i_Dest2(d2), .i_Result2(r2),
    .i_Hold(hold), .o_Ready(rdy),
    .o_WriteBack(wb1), .o_WriteBack2(wb2),
    .o_AddrRegDest(a1), .o_AddrRegDest2(a2),
    .o_WriteData(wd1), .o_WriteData2(wd2),
    .o_Pending(pnd), .o_Overflow(ovf)
  );

  typedef struct {
    logic       v1;
    logic [2:0] d1;
    logic [7:0] r1;
    logic       v2;
    logic [2:0] d2;
    logic [7:0] r2;
  } mpair_t;

  typedef struct {
    logic       v1;
    logic [2:0] d1;
    logic [7:0] r1;
    logic       v2;
    logic [2:0] d2;
    logic [7:0] r2;
    logic       eWb1;
    logic       eWb2;
    logic [2:0] eA1;
    logic [2:0] eA2;
    logic [7:0] eD1;
    logic [7:0] eD2;
    logic [7:0] ePend;
  } vec_t;

  int nVec = 0;
  int nBad = 0;

  mpair_t q[$];
  mpair_t enP, daP;
  bit     enLive, daLive, mOvf;

  logic [7:0] bank [8];
  logic       bEn1, bEn2;
  logic [2:0] bA1, bA2;
  int         bankWrites = 0;

  // bank side of the protocol: latch enable/address, write data next edge
  always @(posedge clk or negedge rstN) begin
    if (!rstN) begin
      bEn1 <= 1'b0;
      bEn2 <= 1'b0;
    end else begin
      bEn1 <= wb1;
      bEn2 <= wb2;
      bA1  <= a1;
      bA2  <= a2;
      if (bEn1) bank[bA1] <= wd1;
      if (bEn2) bank[bA2] <= wd2;
      bankWrites <= bankWrites + int'(bEn1) + int'(bEn2);
    end
  end

  task automatic chk(string nm, logic [31:0] act, logic [31:0] exp);
    nVec++;
    if (act !== exp) begin
      nBad++;
      $display("FAIL %s: got %0h want %0h at %0t", nm, act, exp, $time);
    end
  endtask

  function automatic mpair_t mk(logic a, logic [2:0] b, logic [7:0] c,
                                logic e, logic [2:0] f, logic [7:0] g);
    mpair_t p;
    p.v1 = a; p.d1 = b; p.r1 = c;
    p.v2 = e; p.d2 = f; p.r2 = g;
    return p;
  endfunction

  function automatic logic [7:0] bitsOf(mpair_t p);
    logic [7:0] b = '0;
    if (p.v1) b[p.d1] = 1'b1;
    if (p.v2) b[p.d2] = 1'b1;
    return b;
  endfunction

  function automatic logic [7:0] modelPend();
    logic [7:0] b = '0;
    foreach (q[i]) b |= bitsOf(q[i]);
    if (enLive) b |= bitsOf(enP);
    if (daLive) b |= bitsOf(daP);
    return b;
  endfunction

  task automatic modelStep(mpair_t p, logic h);
    mpair_t pp = p;
    bit anyV = p.v1 | p.v2;
    bit full = q.size() >= DEPTH;
    if (p.v1 && p.v2 && p.d1 == p.d2) pp.v1 = 1'b0;
    if (anyV && full) mOvf = 1'b1;
    daP = enP;
    daLive = enLive;
    if (q.size() > 0 && !h) begin
      enP = q.pop_front();
      enLive = 1'b1;
    end else begin
      enLive = 1'b0;
    end
    if (anyV && !full) q.push_back(pp);
  endtask

  task automatic modelCheck();
    chk("ready", rdy, q.size() < DEPTH);
    chk("wb1", wb1, enLive && enP.v1);
    chk("wb2", wb2, enLive && enP.v2);
    if (enLive && enP.v1) chk("addr1", a1, enP.d1);
    if (enLive && enP.v2) chk("addr2", a2, enP.d2);
    if (daLive && daP.v1) chk("wdata1", wd1, daP.r1);
    if (daLive && daP.v2) chk("wdata2", wd2, daP.r2);
    chk("pending", pnd, modelPend());
    chk("overflow", ovf, mOvf);
  endtask

  task automatic cyc(mpair_t p, logic h);
    v1 = p.v1; d1 = p.d1; r1 = p.r1;
    v2 = p.v2; d2 = p.d2; r2 = p.r2;
    hold = h;
    modelStep(p, h);
    @(posedge clk);
    @(negedge clk);
    modelCheck();
  endtask

  task automatic doReset();
    rstN = 1'b0;
    v1 = 0; v2 = 0; d1 = 0; d2 = 0;
    r1 = 0; r2 = 0; hold = 0;
    q.delete();
    enLive = 0; daLive = 0; mOvf = 0;
    enP = mk(0, 0, 0, 0, 0, 0);
    daP = enP;
    #1;
    chk("rst_wb1", wb1, 0);
    chk("rst_wb2", wb2, 0);
    chk("rst_addr", {a1, a2}, 0);
    chk("rst_data", {wd1, wd2}, 0);
    chk("rst_pend", pnd, 0);
    chk("rst_ready", rdy, 1);
    chk("rst_ovf", ovf, 0);
    @(negedge clk);
    rstN = 1'b1;
  endtask

  vec_t   tbl [5];
  mpair_t idle;
  int     snap;

  initial begin
    idle = mk(0, 0, 0, 0, 0, 0);
    tbl[0] = '{1'b1, 3'd2, 8'h5A, 1'b1, 3'd5, 8'hC3,
               1'b1, 1'b1, 3'd2, 3'd5, 8'h5A, 8'hC3, 8'h24};
    tbl[1] = '{1'b1, 3'd3, 8'h11, 1'b1, 3'd3, 8'h22,
               1'b0, 1'b1, 3'd0, 3'd3, 8'h00, 8'h22, 8'h08};
    tbl[2] = '{1'b1, 3'd0, 8'hFF, 1'b0, 3'd7, 8'h00,
               1'b1, 1'b0, 3'd0, 3'd0, 8'hFF, 8'h00, 8'h01};
    tbl[3] = '{1'b0, 3'd1, 8'h00, 1'b1, 3'd7, 8'h81,
               1'b0, 1'b1, 3'd0, 3'd7, 8'h00, 8'h81, 8'h80};
    tbl[4] = '{1'b1, 3'd6, 8'h3C, 1'b1, 3'd1, 8'hA5,
               1'b1, 1'b1, 3'd6, 3'd1, 8'h3C, 8'hA5, 8'h42};

    for (int i = 0; i < 5; i++) begin
      doReset();
      cyc(mk(tbl[i].v1, tbl[i].d1, tbl[i].r1,
             tbl[i].v2, tbl[i].d2, tbl[i].r2), 1'b0);
      chk("t_pend1", pnd, tbl[i].ePend);
      cyc(idle, 1'b0);
      chk("t_wb1", wb1, tbl[i].eWb1);
      chk("t_wb2", wb2, tbl[i].eWb2);
      if (tbl[i].eWb1) chk("t_addr1", a1, tbl[i].eA1);
      if (tbl[i].eWb2) chk("t_addr2", a2, tbl[i].eA2);
      chk("t_pend2", pnd, tbl[i].ePend);
      cyc(idle, 1'b0);
      chk("t_wbOff", {wb1, wb2}, 0);
      if (tbl[i].eWb1) chk("t_data1", wd1, tbl[i].eD1);
      if (tbl[i].eWb2) chk("t_data2", wd2, tbl[i].eD2);
      chk("t_pend3", pnd, tbl[i].ePend);
      cyc(idle, 1'b0);
      chk("t_pend4", pnd, 0);
      if (tbl[i].eWb1) chk("t_bank1", bank[tbl[i].eA1], tbl[i].eD1);
      if (tbl[i].eWb2) chk("t_bank2", bank[tbl[i].eA2], tbl[i].eD2);
    end

    doReset();
    for (int i = 0; i < 5; i++) begin
      cyc(mk(1, 3'(i), 8'(8'h10 + i), 1, 3'(i + 3), 8'(8'h80 + i)), 1'b1);
      if (i == 3) chk("h_notReady", rdy, 0);
    end
    chk("h_ovfSet", ovf, 1);
    for (int i = 0; i < 6; i++) cyc(idle, 1'b0);
    chk("h_ovfSticky", ovf, 1);
    chk("h_readyAgain", rdy, 1);

    doReset();
    cyc(mk(1, 3'd1, 8'hA1, 1, 3'd2, 8'hA2), 1'b0);
    cyc(mk(1, 3'd4, 8'hB1, 1, 3'd6, 8'hB2), 1'b0);
    cyc(idle, 1'b1);
    chk("m_dataA", {wd1, wd2}, 16'hA1A2);
    chk("m_enOff", {wb1, wb2}, 0);
    cyc(idle, 1'b1);
    cyc(idle, 1'b1);
    chk("m_stillOff", {wb1, wb2}, 0);
    cyc(idle, 1'b0);
    chk("m_popB", {wb1, wb2, a1, a2}, {2'b11, 3'd4, 3'd6});
    for (int i = 0; i < 3; i++) cyc(idle, 1'b0);

    doReset();
    for (int i = 0; i < 10; i++)
      cyc(mk(1, 3'(i), 8'(i * 17), 1, 3'(7 - (i % 4)), 8'(8'hF0 - i)), 1'b0);
    for (int i = 0; i < 4; i++) cyc(idle, 1'b0);

    doReset();
    for (int i = 0; i < 4; i++)
      cyc(mk(1, 3'(i), 8'(8'h40 + i), 1, 3'(i + 4), 8'(8'h50 + i)), 1'b1);
    cyc(idle, 1'b0);
    chk("r_inFlight", wb1, 1);
    doReset();
    snap = bankWrites;
    for (int i = 0; i < 6; i++) cyc(idle, 1'b0);
    chk("r_noWrites", bankWrites, snap);

    doReset();
    for (int i = 0; i < 400; i++) begin
      logic h;
      if (((i / 25) % 2) == 1) h = ($urandom_range(0, 3) != 0);
      else h = ($urandom_range(0, 3) == 0);
      cyc(mk(1'($urandom_range(0, 1)), 3'($urandom_range(0, 7)),
             8'($urandom), 1'($urandom_range(0, 1)),
             3'($urandom_range(0, 7)), 8'($urandom)), h);
    end
    for (int i = 0; i < 8; i++) cyc(idle, 1'b0);

    $display("== %0d vectors applied, %0d miscompares ==", nVec, nBad);
    $finish;
  end

endmodule
